snake_controller_gen: RTL and testbench
=======================================

Name: snake_controller_gen

Overview:
- Parametrised next-generation game controller for the snake datapath.
- Sequences the tick loop: check, input, wait-for-logic, display.
- Multiplexes an ROWS x COLS LED matrix and owns game, direction and execution state.
- Over the fixed 8x8 controller it adds pause, a buffered direction queue, speed levels that shorten the tick period as the snake grows, and a logic-handshake timeout.

Parameters:
- ROWS, 8, display rows; also the row_cathode width.
- COLS, 8, display columns; also the column_anode width.
- DISPLAY_CYCLES, 8, full display frames per tick at speed level 0.
- NUM_SPEEDS, 4, number of speed levels; level s shows max(1, DISPLAY_CYCLES>>s) frames per tick.
- LOGIC_TIMEOUT, 64, maximum clka cycles spent in WAIT_LOGIC before forced exit.

Ports:
- clka  in  1  system clock; all state updates on the rising edge.
- restart_n  in  1  reset, synchronous, active-low.
- direction_in  in  4  buttons, active high: bit0 up, bit1 down, bit2 left, bit3 right.
- pause_in  in  1  pause button, level input.
- from_logic  in  3  bit0 LOGIC_DONE, bit1 GAME_END, bit2 GROW (apple eaten this tick).
- led_array_flat  in  ROWS*COLS  row r occupies bits [r*COLS +: COLS].
- game_state  out  2  0 INIT, 1 RUN, 2 STOP, 3 PAUSE.
- direction_state  out  2  0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- execution_state  out  2  0 CHECK_STATE, 1 INPUT, 2 WAIT_LOGIC, 3 DISPLAY.
- to_logic  out  2  bit0 LOGIC_TICK, bit1 NO_UPDATE.
- speed_level  out  clog2(NUM_SPEEDS)  current speed level.
- logic_timeout  out  1  sticky: set once any WAIT_LOGIC has timed out.
- row_cathode  out  ROWS  one-cold row enable.
- column_anode  out  COLS  lit columns of the enabled row.

Behaviour:
- Reset (restart_n low at an edge):
  - game_state INIT, direction_state RIGHT, execution_state CHECK_STATE.
  - to_logic 0, speed_level 0, logic_timeout 0.
  - row_cathode all ones, column_anode 0.
  - Pending-direction buffer empty; row and frame counters 0; pause edge detector cleared.
  - Reset mid-operation aborts any state in the same edge.
- Direction buffer:
  - Each cycle, a one-hot direction_in is captured into the pending register if the buffer is empty, the direction is not a reversal of direction_state, and it differs from direction_state.
  - Multi-hot or zero input is ignored.
  - First valid press wins until the buffer is consumed.
- Game FSM:
  - INIT->RUN on any non-zero direction_in.
  - RUN->STOP when GAME_END is sampled in WAIT_LOGIC.
  - RUN<->PAUSE on a pause_in rising edge. Pause edges are ignored in INIT and STOP.
  - STOP is left only by reset.
  - If GAME_END and a pause edge occur in the same cycle, STOP wins.
- Execution FSM:
  - CHECK_STATE: goes to DISPLAY if game_state is INIT or PAUSE, otherwise to INPUT.
  - INPUT (one cycle):
    - direction_state takes the pending value if valid; the buffer then clears.
    - to_logic[0]=1 for exactly this cycle.
    - to_logic[1]=1 if game_state is STOP.
  - WAIT_LOGIC: goes to DISPLAY on LOGIC_DONE.
    - If GROW=1 in the same cycle, speed_level increments, saturating at NUM_SPEEDS-1.
    - After LOGIC_TIMEOUT cycles without LOGIC_DONE: goes to DISPLAY, logic_timeout sets, and no speed change.
  - DISPLAY: row counter runs 0..ROWS-1, one row per cycle; the frame counter increments at wrap.
    - Exit to CHECK_STATE after the last row of frame max(1, DISPLAY_CYCLES>>speed_level)-1.
    - The frame target is sampled at DISPLAY entry.
- Display outputs:
  - Registered; in the same cycle as row r is shown, row_cathode bit r is 0 and all other bits are 1.
  - column_anode = row r of led_array_flat.
  - In all other execution states: row_cathode all ones, column_anode 0.
- Tick period in cycles: 2 + wait time + ROWS*frames.

Decomposition:
- Shared package snake_pkg holds:
  - game, direction and execution state encodings;
  - from_logic and to_logic bit indices;
  - button one-hot constants.
- One sub-module, snake_display_mux: takes ROWS, COLS, an enable, the flat array and a frame target; outputs row_cathode, column_anode and frame_done.

Test Plan:
- Reset, then direction_in=4'b1000 for 1 cycle -> game_state RUN; INPUT asserts to_logic=2'b01 for exactly 1 cycle; direction_state stays RIGHT(3).
- In RUN facing RIGHT, press LEFT then UP in the same tick window -> LEFT ignored as a reversal, UP buffered; at the next INPUT direction_state=0; a later DOWN in the same window is ignored.
- Default params, LOGIC_DONE returned 3 cycles after INPUT -> DISPLAY lasts 64 cycles; row_cathode steps 8'hFE, 8'hFD … 8'h7F eight times.
- Three ticks with GROW=1 alongside LOGIC_DONE -> speed_level 1, 2, 3; a fourth GROW keeps 3; DISPLAY shrinks 32, 16, 8 cycles.
- Pause edge in RUN -> PAUSE: no to_logic pulses, display continues; second edge -> RUN. Pause edge in INIT has no effect.
- LOGIC_DONE never asserted -> DISPLAY entered after 64 WAIT_LOGIC cycles, logic_timeout=1 and held; restart_n low mid-DISPLAY -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: state enums, from_logic/to_logic
// bit positions and the direction button one-hot codes.
package snake_pkg;

  typedef enum logic [1:0] {
    GS_INIT  = 2'd0,
    GS_RUN   = 2'd1,
    GS_STOP  = 2'd2,
    GS_PAUSE = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_state_t;

  typedef enum logic [1:0] {
    EX_CHECK   = 2'd0,
    EX_INPUT   = 2'd1,
    EX_WAIT    = 2'd2,
    EX_DISPLAY = 2'd3
  } exec_state_t;

  localparam int unsigned FL_DONE      = 0;
  localparam int unsigned FL_END       = 1;
  localparam int unsigned FL_GROW      = 2;
  localparam int unsigned TL_TICK      = 0;
  localparam int unsigned TL_NO_UPDATE = 1;

  localparam logic [3:0] BTN_UP    = 4'b0001;
  localparam logic [3:0] BTN_DOWN  = 4'b0010;
  localparam logic [3:0] BTN_LEFT  = 4'b0100;
  localparam logic [3:0] BTN_RIGHT = 4'b1000;

  // Opposite directions differ only in the LSB of their encoding.
  function automatic logic is_reversal(input dir_state_t a, input dir_state_t b);
    logic [1:0] w_a;
    logic [1:0] w_b;
    w_a = a;
    w_b = b;
    return (w_a ^ w_b) == 2'b01;
  endfunction

  function automatic dir_state_t btn_to_dir(input logic [3:0] btn);
    case (btn)
      BTN_UP:   return DIR_UP;
      BTN_DOWN: return DIR_DOWN;
      BTN_LEFT: return DIR_LEFT;
      default:  return DIR_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/snake_display_mux.sv
// LED matrix row scanner: while enabled, shows one row per cycle and flags the
// last row of the last requested frame.
module snake_display_mux
  import snake_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int FW   = 4
) (
  input  logic                 clka,
  input  logic                 restart_n,
  input  logic                 i_enable,
  input  logic [ROWS*COLS-1:0] i_led_array_flat,
  input  logic [FW-1:0]        i_frame_target,
  output logic [ROWS-1:0]      o_row_cathode,
  output logic [COLS-1:0]      o_column_anode,
  output logic                 o_frame_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [RW-1:0] r_row;
  logic [FW-1:0] r_frame;
  logic [FW-1:0] r_target;
  logic          r_active;
  logic [FW-1:0] w_target;
  logic          w_last_row;
  logic          w_last;

  // The target is captured on the first enabled cycle and held for the whole burst.
  assign w_target   = r_active ? r_target : i_frame_target;
  assign w_last_row = (r_row == RW'(ROWS - 1));
  assign w_last     = w_last_row && (r_frame == (w_target - FW'(1)));

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      r_row          <= '0;
      r_frame        <= '0;
      r_target       <= '0;
      r_active       <= 1'b0;
      o_row_cathode  <= '1;
      o_column_anode <= '0;
      o_frame_done   <= 1'b0;
    end else if (i_enable) begin
      r_active       <= 1'b1;
      r_target       <= w_target;
      o_row_cathode  <= ~(ROWS'(1) << r_row);
      o_column_anode <= i_led_array_flat[int'(r_row)*COLS +: COLS];
      o_frame_done   <= w_last;
      if (w_last_row) begin
        r_row   <= '0;
        r_frame <= r_frame + FW'(1);
      end else begin
        r_row <= r_row + RW'(1);
      end
    end else begin
      r_row          <= '0;
      r_frame        <= '0;
      r_active       <= 1'b0;
      o_row_cathode  <= '1;
      o_column_anode <= '0;
      o_frame_done   <= 1'b0;
    end
  end

endmodule

// File: rtl/snake_controller_gen.sv
// Snake game controller: sequences check/input/wait-logic/display ticks, buffers
// direction presses, handles pause, speed levels and the logic-handshake timeout.
module snake_controller_gen
  import snake_pkg::*;
#(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int DISPLAY_CYCLES = 8,
  parameter int NUM_SPEEDS     = 4,
  parameter int LOGIC_TIMEOUT  = 64,
  localparam int SPD_W = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1,
  localparam int FW    = $clog2(DISPLAY_CYCLES + 1),
  localparam int TW    = (LOGIC_TIMEOUT > 1) ? $clog2(LOGIC_TIMEOUT) : 1
) (
  input  logic                 clka,
  input  logic                 restart_n,
  input  logic [3:0]           direction_in,
  input  logic                 pause_in,
  input  logic [2:0]           from_logic,
  input  logic [ROWS*COLS-1:0] led_array_flat,
  output logic [1:0]           game_state,
  output logic [1:0]           direction_state,
  output logic [1:0]           execution_state,
  output logic [1:0]           to_logic,
  output logic [SPD_W-1:0]     speed_level,
  output logic                 logic_timeout,
  output logic [ROWS-1:0]      row_cathode,
  output logic [COLS-1:0]      column_anode
);

  game_state_t      r_game;
  dir_state_t       r_dir;
  dir_state_t       r_pend;
  exec_state_t      r_exec;
  logic             r_pend_valid;
  logic             r_pause_prev;
  logic [1:0]       r_to_logic;
  logic [SPD_W-1:0] r_speed;
  logic             r_timeout;
  logic [TW-1:0]    r_wait_cnt;

  logic             w_pause_edge;
  logic             w_onehot;
  dir_state_t       w_btn_dir;
  logic             w_done;
  logic             w_timeout_hit;
  logic             w_disp_next;
  logic             w_frame_done;
  logic [SPD_W-1:0] w_speed_next;
  logic [FW-1:0]    w_frame_target;

  function automatic logic [FW-1:0] frames_for(input logic [SPD_W-1:0] s);
    int unsigned f;
    f = DISPLAY_CYCLES >> s;
    if (f == 0) f = 1;
    return FW'(f);
  endfunction

  assign w_pause_edge  = pause_in & ~r_pause_prev;
  assign w_btn_dir     = btn_to_dir(direction_in);
  assign w_done        = from_logic[FL_DONE];
  assign w_timeout_hit = (r_wait_cnt == TW'(LOGIC_TIMEOUT - 1));

  always_comb begin
    w_onehot = 1'b0;
    case (direction_in)
      BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT: w_onehot = 1'b1;
      default:                               w_onehot = 1'b0;
    endcase
  end

  // Speed as it will be after this edge, so a GROW tick already displays faster.
  always_comb begin
    w_speed_next = r_speed;
    if (r_exec == EX_WAIT && w_done && from_logic[FL_GROW] &&
        r_speed != SPD_W'(NUM_SPEEDS - 1))
      w_speed_next = r_speed + SPD_W'(1);
  end

  always_comb begin
    w_disp_next = 1'b0;
    case (r_exec)
      EX_CHECK:   w_disp_next = (r_game == GS_INIT) || (r_game == GS_PAUSE);
      EX_WAIT:    w_disp_next = w_done || w_timeout_hit;
      EX_DISPLAY: w_disp_next = !w_frame_done;
      default:    w_disp_next = 1'b0;
    endcase
  end

  assign w_frame_target = frames_for(w_speed_next);

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      r_game       <= GS_INIT;
      r_dir        <= DIR_RIGHT;
      r_pend       <= DIR_UP;
      r_pend_valid <= 1'b0;
      r_exec       <= EX_CHECK;
      r_pause_prev <= 1'b0;
      r_to_logic   <= '0;
      r_speed      <= '0;
      r_timeout    <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_pause_prev <= pause_in;

      case (r_game)
        GS_INIT:  if (|direction_in) r_game <= GS_RUN;
        GS_RUN: begin
          if (r_exec == EX_WAIT && from_logic[FL_END]) r_game <= GS_STOP;
          else if (w_pause_edge)                       r_game <= GS_PAUSE;
        end
        GS_PAUSE: if (w_pause_edge) r_game <= GS_RUN;
        default:  r_game <= r_game;
      endcase

      // Consumption in INPUT takes priority over a press arriving in that same cycle.
      if (r_exec == EX_INPUT) begin
        if (r_pend_valid) r_dir <= r_pend;
        r_pend_valid <= 1'b0;
      end else if (!r_pend_valid && w_onehot && w_btn_dir != r_dir &&
                   !is_reversal(w_btn_dir, r_dir)) begin
        r_pend       <= w_btn_dir;
        r_pend_valid <= 1'b1;
      end

      r_to_logic <= '0;
      case (r_exec)
        EX_CHECK: begin
          if (w_disp_next) begin
            r_exec <= EX_DISPLAY;
          end else begin
            r_exec                   <= EX_INPUT;
            r_to_logic[TL_TICK]      <= 1'b1;
            r_to_logic[TL_NO_UPDATE] <= (r_game == GS_STOP);
          end
        end
        EX_INPUT: begin
          r_exec     <= EX_WAIT;
          r_wait_cnt <= '0;
        end
        EX_WAIT: begin
          if (w_done) begin
            r_exec  <= EX_DISPLAY;
            r_speed <= w_speed_next;
          end else if (w_timeout_hit) begin
            r_exec    <= EX_DISPLAY;
            r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        default: if (!w_disp_next) r_exec <= EX_CHECK;
      endcase
    end
  end

  snake_display_mux #(
    .ROWS (ROWS),
    .COLS (COLS),
    .FW   (FW)
  ) u_display_mux (
    .clka             (clka),
    .restart_n        (restart_n),
    .i_enable         (w_disp_next),
    .i_led_array_flat (led_array_flat),
    .i_frame_target   (w_frame_target),
    .o_row_cathode    (row_cathode),
    .o_column_anode   (column_anode),
    .o_frame_done     (w_frame_done)
  );

  assign game_state      = r_game;
  assign direction_state = r_dir;
  assign execution_state = r_exec;
  assign to_logic        = r_to_logic;
  assign speed_level     = r_speed;
  assign logic_timeout   = r_timeout;

endmodule

// File: tb/tb_snake_controller_gen.sv
// Bench for snake_controller_gen: directed vector table, timeout/reset sequence and
// randomized run, all cross-checked every cycle against a tick-level model.
module tb_snake_controller_gen;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DC   = 8;
  localparam int NS   = 4;
  localparam int TO   = 64;

  logic             clka = 1'b0;
  logic             restart_n;
  logic [3:0]       direction_in;
  logic             pause_in;
  logic [2:0]       from_logic;
  logic [ROWS*COLS-1:0] led_array_flat;
  logic [1:0]       game_state;
  logic [1:0]       direction_state;
  logic [1:0]       execution_state;
  logic [1:0]       to_logic;
  logic [1:0]       speed_level;
  logic             logic_timeout;
  logic [ROWS-1:0]  row_cathode;
  logic [COLS-1:0]  column_anode;

  always #5 clka = ~clka;

  snake_controller_gen #(
    .ROWS           (ROWS),
    .COLS           (COLS),
    .DISPLAY_CYCLES (DC),
    .NUM_SPEEDS     (NS),
    .LOGIC_TIMEOUT  (TO)
  ) dut (
    .clka            (clka),
    .restart_n       (restart_n),
    .direction_in    (direction_in),
    .pause_in        (pause_in),
    .from_logic      (from_logic),
    .led_array_flat  (led_array_flat),
    .game_state      (game_state),
    .direction_state (direction_state),
    .execution_state (execution_state),
    .to_logic        (to_logic),
    .speed_level     (speed_level),
    .logic_timeout   (logic_timeout),
    .row_cathode     (row_cathode),
    .column_anode    (column_anode)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] led;

  // Model: game 0 INIT/1 RUN/2 STOP/3 PAUSE, dir 0 U/1 D/2 L/3 R,
  // phase 0 check/1 input/2 wait/3 display, cyc = cycles already spent in phase.
  int m_game, m_dir, m_phase, m_cyc, m_speed, m_tmo, m_pend, m_prev_pause, m_frames;
  int m_col;

  typedef struct {
    int         n;
    logic [3:0] d;
    bit         p;
    logic [2:0] fl;
    int         game;
    int         dir;
    int         ex;
    int         tl;
    int         spd;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int frames_at(input int s);
    int f;
    f = DC >> s;
    return (f < 1) ? 1 : f;
  endfunction

  task automatic model_edge(input bit rst_n, input logic [3:0] d, input bit p,
                            input logic [2:0] fl);
    int ng, idx, ones;
    bit pedge;
    if (!rst_n) begin
      m_game = 0; m_dir = 3; m_phase = 0; m_cyc = 0; m_speed = 0;
      m_tmo = 0; m_pend = -1; m_prev_pause = 0; m_frames = 1; m_col = 0;
      return;
    end
    pedge = p && (m_prev_pause == 0);
    m_prev_pause = p;
    ng = m_game;
    case (m_game)
      0: if (d != 0) ng = 1;
      1: if (m_phase == 2 && fl[1]) ng = 2; else if (pedge) ng = 3;
      3: if (pedge) ng = 1;
      default: ng = m_game;
    endcase
    ones = 0; idx = 0;
    for (int b = 0; b < 4; b++) if (d[b]) begin ones++; idx = b; end
    if (m_phase == 1) begin
      if (m_pend >= 0) m_dir = m_pend;
      m_pend = -1;
    end else if (m_pend < 0 && ones == 1 && idx != m_dir && idx != opposite(m_dir)) begin
      m_pend = idx;
    end
    case (m_phase)
      0: begin
        if (m_game == 0 || m_game == 3) begin
          m_phase = 3; m_cyc = 0; m_frames = frames_at(m_speed);
        end else m_phase = 1;
      end
      1: begin m_phase = 2; m_cyc = 0; end
      2: begin
        if (fl[0]) begin
          if (fl[2] && m_speed < NS - 1) m_speed++;
          m_phase = 3; m_cyc = 0; m_frames = frames_at(m_speed);
        end else if (m_cyc + 1 == TO) begin
          m_tmo = 1; m_phase = 3; m_cyc = 0; m_frames = frames_at(m_speed);
        end else m_cyc++;
      end
      default: begin
        if (m_cyc + 1 == ROWS * m_frames) m_phase = 0;
        else m_cyc++;
      end
    endcase
    m_game = ng;
    m_col = (m_phase == 3) ? int'(led[(m_cyc % ROWS)*COLS +: COLS]) : 0;
  endtask

  task automatic compare_model();
    int rc;
    rc = (m_phase == 3) ? ((~(1 << (m_cyc % ROWS))) & 'hFF) : 'hFF;
    chk("model.game_state", int'(game_state), m_game);
    chk("model.direction_state", int'(direction_state), m_dir);
    chk("model.execution_state", int'(execution_state), m_phase);
    chk("model.to_logic", int'(to_logic),
        (m_phase == 1) ? ((m_game == 2) ? 3 : 1) : 0);
    chk("model.speed_level", int'(speed_level), m_speed);
    chk("model.logic_timeout", int'(logic_timeout), m_tmo);
    chk("model.row_cathode", int'(row_cathode), rc);
    chk("model.column_anode", int'(column_anode), m_col);
  endtask

  task automatic step(input bit rst_n, input logic [3:0] d, input bit p,
                      input logic [2:0] fl);
    restart_n      = rst_n;
    direction_in   = d;
    pause_in       = p;
    from_logic     = fl;
    led_array_flat = led;
    @(posedge clka);
    model_edge(rst_n, d, p, fl);
    @(negedge clka);
    compare_model();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".game_state"}, int'(game_state), 0);
    chk({tag, ".direction_state"}, int'(direction_state), 3);
    chk({tag, ".execution_state"}, int'(execution_state), 0);
    chk({tag, ".to_logic"}, int'(to_logic), 0);
    chk({tag, ".speed_level"}, int'(speed_level), 0);
    chk({tag, ".logic_timeout"}, int'(logic_timeout), 0);
    chk({tag, ".row_cathode"}, int'(row_cathode), 'hFF);
    chk({tag, ".column_anode"}, int'(column_anode), 0);
  endtask

  function automatic void add(input int n, input logic [3:0] d, input bit p,
                              input logic [2:0] fl, input int game, input int dir,
                              input int ex, input int tl, input int spd);
    vec_t v;
    v.n = n; v.d = d; v.p = p; v.fl = fl;
    v.game = game; v.dir = dir; v.ex = ex; v.tl = tl; v.spd = spd;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] d;
    logic [2:0] fl;
    bit         p;
    bit         rn;
    int         r;

    led = 64'h8142_2418_A55A_C3E7;
    restart_n = 1'b0; direction_in = '0; pause_in = 1'b0; from_logic = '0;
    led_array_flat = led;

    //        n   dir     p  fl      game dir ex tl spd
    add(1,  4'b1000, 0, 3'b000, 1, 3, 3, 0, 0);
    add(63, 4'b0000, 0, 3'b000, 1, 3, 3, 0, 0);
    add(1,  4'b0000, 0, 3'b000, 1, 3, 0, 0, 0);
    add(1,  4'b0000, 0, 3'b000, 1, 3, 1, 1, 0);
    add(1,  4'b0000, 0, 3'b000, 1, 3, 2, 0, 0);
    add(2,  4'b0000, 0, 3'b000, 1, 3, 2, 0, 0);
    add(1,  4'b0000, 0, 3'b001, 1, 3, 3, 0, 0);
    add(1,  4'b0100, 0, 3'b000, 1, 3, 3, 0, 0);
    add(1,  4'b0001, 0, 3'b000, 1, 3, 3, 0, 0);
    add(1,  4'b0010, 0, 3'b000, 1, 3, 3, 0, 0);
    add(60, 4'b0000, 0, 3'b000, 1, 3, 3, 0, 0);
    add(1,  4'b0000, 0, 3'b000, 1, 3, 0, 0, 0);
    add(1,  4'b0000, 0, 3'b000, 1, 3, 1, 1, 0);
    add(1,  4'b0000, 0, 3'b000, 1, 0, 2, 0, 0);
    add(1,  4'b0000, 0, 3'b101, 1, 0, 3, 0, 1);
    add(31, 4'b0000, 0, 3'b000, 1, 0, 3, 0, 1);
    add(1,  4'b0000, 0, 3'b000, 1, 0, 0, 0, 1);
    add(1,  4'b0000, 0, 3'b000, 1, 0, 1, 1, 1);
    add(1,  4'b0000, 0, 3'b000, 1, 0, 2, 0, 1);
    add(1,  4'b0000, 0, 3'b101, 1, 0, 3, 0, 2);
    add(15, 4'b0000, 0, 3'b000, 1, 0, 3, 0, 2);
    add(1,  4'b0000, 0, 3'b000, 1, 0, 0, 0, 2);
    add(2,  4'b0000, 0, 3'b000, 1, 0, 2, 0, 2);
    add(1,  4'b0000, 0, 3'b101, 1, 0, 3, 0, 3);
    add(7,  4'b0000, 0, 3'b000, 1, 0, 3, 0, 3);
    add(1,  4'b0000, 0, 3'b000, 1, 0, 0, 0, 3);
    add(2,  4'b0000, 0, 3'b000, 1, 0, 2, 0, 3);
    add(1,  4'b0000, 0, 3'b101, 1, 0, 3, 0, 3);
    add(6,  4'b0000, 0, 3'b000, 1, 0, 3, 0, 3);
    add(1,  4'b0000, 1, 3'b000, 3, 0, 3, 0, 3);
    add(1,  4'b0000, 1, 3'b000, 3, 0, 0, 0, 3);
    add(1,  4'b0000, 0, 3'b000, 3, 0, 3, 0, 3);
    add(7,  4'b0000, 0, 3'b000, 3, 0, 3, 0, 3);
    add(1,  4'b0000, 0, 3'b000, 3, 0, 0, 0, 3);
    add(1,  4'b0000, 1, 3'b000, 1, 0, 3, 0, 3);
    add(7,  4'b0000, 0, 3'b000, 1, 0, 3, 0, 3);
    add(1,  4'b0000, 0, 3'b000, 1, 0, 0, 0, 3);
    add(1,  4'b0000, 0, 3'b000, 1, 0, 1, 1, 3);
    add(1,  4'b0000, 0, 3'b010, 1, 0, 2, 0, 3);
    add(1,  4'b0000, 1, 3'b011, 2, 0, 3, 0, 3);
    add(8,  4'b0000, 0, 3'b000, 2, 0, 0, 0, 3);
    add(1,  4'b0000, 0, 3'b000, 2, 0, 1, 3, 3);
    add(1,  4'b0000, 1, 3'b000, 2, 0, 2, 0, 3);

    // Reset values, then pause edges while in INIT must not leave INIT.
    step(0, 4'b0000, 0, 3'b000);
    chk_reset_values("reset");
    repeat (3) step(1, 4'b0000, 1, 3'b000);
    chk("init_pause.game_state", int'(game_state), 0);

    step(0, 4'b0000, 0, 3'b000);
    foreach (tbl[i]) begin
      repeat (tbl[i].n) step(1, tbl[i].d, tbl[i].p, tbl[i].fl);
      chk($sformatf("tbl[%0d].game_state", i), int'(game_state), tbl[i].game);
      chk($sformatf("tbl[%0d].direction_state", i), int'(direction_state), tbl[i].dir);
      chk($sformatf("tbl[%0d].execution_state", i), int'(execution_state), tbl[i].ex);
      chk($sformatf("tbl[%0d].to_logic", i), int'(to_logic), tbl[i].tl);
      chk($sformatf("tbl[%0d].speed_level", i), int'(speed_level), tbl[i].spd);
    end

    // Handshake timeout, sticky flag, then reset in the middle of DISPLAY.
    step(0, 4'b0000, 0, 3'b000);
    step(1, 4'b1000, 0, 3'b000);
    repeat (63) step(1, 4'b0000, 0, 3'b000);
    repeat (3) step(1, 4'b0000, 0, 3'b000);
    chk("timeout.enter_wait", int'(execution_state), 2);
    repeat (63) step(1, 4'b0000, 0, 3'b000);
    chk("timeout.still_wait", int'(execution_state), 2);
    chk("timeout.flag_before", int'(logic_timeout), 0);
    step(1, 4'b0000, 0, 3'b000);
    chk("timeout.exec_display", int'(execution_state), 3);
    chk("timeout.flag_set", int'(logic_timeout), 1);
    chk("timeout.speed_kept", int'(speed_level), 0);
    repeat (10) step(1, 4'b0000, 0, 3'b000);
    chk("timeout.flag_held", int'(logic_timeout), 1);
    step(0, 4'b0000, 0, 3'b000);
    chk_reset_values("mid_display_reset");

    // Randomized run against the model.
    p = 0;
    for (int c = 0; c < 6000; c++) begin
      rn = ($urandom_range(0, 799) != 0);
      r = $urandom_range(0, 15);
      if (r < 2)      d = 4'($urandom_range(1, 15));
      else if (r < 5) d = 4'(1 << $urandom_range(0, 3));
      else            d = 4'b0000;
      if ($urandom_range(0, 299) == 0) p = ~p;
      fl[0] = ($urandom_range(0, 3) == 0);
      fl[1] = ($urandom_range(0, 399) == 0);
      fl[2] = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 31) == 0) led = {$urandom, $urandom};
      step(rn, d, p, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
